sub_bytes_seq: RTL and testbench

SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/s_box.sv | 14 +
 rtl/sub_bytes_seq.sv | 153 +++++++++++++++
 tb/tb_sub_bytes_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, SubBytes FSM states and
// GF(2^8) helpers used by the s_box lanes.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/s_box.sv
// Single-byte AES S-box, forward (enc=1) or inverse (enc=0).
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic       enc,
  output logic [7:0] q
);

  always_comb begin
    q = enc ? sbox_fwd(a) : sbox_inv(a);
  end

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per cycle.
// Optional macro SUB_BYTES_SBOX_REG_EN registers the s_box outputs (one extra drain cycle).
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enc,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  localparam int unsigned BPC    = BYTES_PER_CYCLE;
  localparam int unsigned LANE_W = BPC * BYTE_W;
  localparam int unsigned CHUNKS = AES_BYTES / BPC;
  localparam int unsigned KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

  sb_state_e                     state;
  sb_state_e                     state_nx;
  logic [KW-1:0]                 k;
  logic                          enc_q;
  logic [CHUNKS-1:0][LANE_W-1:0] work;
  logic [LANE_W-1:0]             sb_a;
  logic [LANE_W-1:0]             sb_q;
  logic                          accept;
  logic                          step;
  logic                          wr_en;
  logic                          run_done;
  logic [KW-1:0]                 wr_k;
  logic [LANE_W-1:0]             wr_data;

  assign accept = in_valid && in_ready;
  assign sb_a   = work[k];

  for (genvar l = 0; l < BPC; l++) begin : g_lane
    s_box u_s_box (
      .a   (sb_a[l*BYTE_W +: BYTE_W]),
      .enc (enc_q),
      .q   (sb_q[l*BYTE_W +: BYTE_W])
    );
  end

`ifdef SUB_BYTES_SBOX_REG_EN
  // Lane results are written one cycle after their chunk is read.
  logic [LANE_W-1:0] sb_r;
  logic [KW-1:0]     wr_k_r;
  logic              wr_v_r;
  logic              issued_all;

  assign step = (state == RUN) && !issued_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_r       <= '0;
      wr_k_r     <= '0;
      wr_v_r     <= 1'b0;
      issued_all <= 1'b0;
    end else begin
      sb_r   <= sb_q;
      wr_k_r <= k;
      wr_v_r <= step;
      if (accept) begin
        issued_all <= 1'b0;
      end else if (step && (k == K_LAST)) begin
        issued_all <= 1'b1;
      end
    end
  end

  assign wr_en    = wr_v_r;
  assign wr_k     = wr_k_r;
  assign wr_data  = sb_r;
  assign run_done = (state == RUN) && issued_all;
`else
  assign step     = (state == RUN);
  assign wr_en    = step;
  assign wr_k     = k;
  assign wr_data  = sb_q;
  assign run_done = step && (k == K_LAST);
`endif

  // Chunk counter and latched direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      enc_q <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      enc_q <= enc;
    end else if (step) begin
      k <= (k == K_LAST) ? '0 : k + KW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
    end else if (accept) begin
      work <= state_in;
    end else if (wr_en) begin
      work[wr_k] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (run_done) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    if (state == IDLE) begin
      in_ready = 1'b1;
      busy     = 1'b0;
    end
  end

  // Result snapshot: taken on the first DONE cycle and held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      state_out <= '0;
    end else if ((state == DONE) && !out_valid) begin
      out_valid <= 1'b1;
      state_out <= work;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: one instance per legal BYTES_PER_CYCLE,
// index 2 (BPC=4) carries the main scenarios.
module tb_sub_bytes_seq;

  localparam int NI = 5;
  localparam int GM = 2;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] S63 = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [NI];
  logic         en   [NI];
  logic         ordy [NI];
  logic         ir   [NI];
  logic         ov   [NI];
  logic         bsy  [NI];
  logic [127:0] sin  [NI];
  logic [127:0] sout [NI];
  int           pass_cnt = 0;
  int           total    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 16;
    sub_bytes_seq #(.BYTES_PER_CYCLE(B)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .enc       (en[g]),
      .state_in  (sin[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .state_out (sout[g]),
      .busy      (bsy[g])
    );
  end

  function automatic int bpc_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int lat_of(input int g);
`ifdef SUB_BYTES_SBOX_REG_EN
    return 16 / bpc_of(g) + 2;
`else
    return 16 / bpc_of(g) + 1;
`endif
  endfunction

  // Offer one block, then scramble in_valid/enc/state_in while busy; returns cycles to out_valid.
  task automatic send(input int g, input logic e, input logic [127:0] d,
                      output int lat, output logic [127:0] q);
    int w;
    w = 0;
    iv[g] = 1'b1; en[g] = e; sin[g] = d;
    while (!ir[g] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    iv[g] = 1'b1; en[g] = ~e; sin[g] = ~d;
    lat = 0;
    while (!ov[g] && lat < 64) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) iv[g] = 1'b0;
    end
    iv[g] = 1'b0;
    q = sout[g];
  endtask

  task automatic take(input int g);
    ordy[g] = 1'b1;
    @(posedge clk); #1;
    ordy[g] = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (ir[GM] !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir[GM]); else pass_cnt++;
    total++; if (ov[GM] !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov[GM]); else pass_cnt++;
    total++; if (bsy[GM] !== 1'b0) $display("FAIL reset_busy: got %b want 0", bsy[GM]); else pass_cnt++;
    total++; if (sout[GM] !== 128'h0) $display("FAIL reset_state_out: got %h want 0", sout[GM]); else pass_cnt++;
  endtask

  task automatic test_forward();
    int lat;
    logic [127:0] q;
    send(GM, 1'b1, PT, lat, q);
    total++; if (lat !== lat_of(GM)) $display("FAIL fwd_latency: got %0d want %0d", lat, lat_of(GM)); else pass_cnt++;
    total++; if (q !== CT) $display("FAIL fwd_result: got %h want %h", q, CT); else pass_cnt++;
    total++; if (bsy[GM] !== 1'b1) $display("FAIL fwd_busy_in_done: got %b want 1", bsy[GM]); else pass_cnt++;
    take(GM);
    total++; if (ir[GM] !== 1'b1) $display("FAIL fwd_idle_after_take: got %b want 1", ir[GM]); else pass_cnt++;
  endtask

  task automatic test_inverse();
    int lat;
    logic [127:0] q;
    send(GM, 1'b0, CT, lat, q);
    total++; if (q !== PT) $display("FAIL inv_result: got %h want %h", q, PT); else pass_cnt++;
    take(GM);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_ov, bad_out, bad_ir;
    logic [127:0] q;
    bad_ov = 0; bad_out = 0; bad_ir = 0;
    send(GM, 1'b1, S63 ^ S63, lat, q);
    ordy[GM] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov[GM] !== 1'b1) bad_ov++;
      if (sout[GM] !== S63) bad_out++;
      if (ir[GM] !== 1'b0) bad_ir++;
    end
    total++; if (bad_ov != 0) $display("FAIL bp_out_valid_held: %0d cycles dropped, want 0", bad_ov); else pass_cnt++;
    total++; if (bad_out != 0) $display("FAIL bp_state_out_stable: %0d cycles wrong, want 0 (last %h want %h)", bad_out, sout[GM], S63); else pass_cnt++;
    total++; if (bad_ir != 0) $display("FAIL bp_in_ready_low: %0d cycles high, want 0", bad_ir); else pass_cnt++;
    take(GM);
    total++; if (ov[GM] !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", ov[GM]); else pass_cnt++;
    total++; if (ir[GM] !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", ir[GM]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [127:0] q;
    iv[GM] = 1'b1; en[GM] = 1'b1; sin[GM] = PT;
    @(posedge clk); #1;
    iv[GM] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    total++; if (ov[GM] !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", ov[GM]); else pass_cnt++;
    total++; if (ir[GM] !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", ir[GM]); else pass_cnt++;
    total++; if (bsy[GM] !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bsy[GM]); else pass_cnt++;
    total++; if (sout[GM] !== 128'h0) $display("FAIL rst_mid_state_out: got %h want 0", sout[GM]); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(GM, 1'b1, PT, lat, q);
    total++; if (q !== CT) $display("FAIL rst_mid_next_block: got %h want %h", q, CT); else pass_cnt++;
    take(GM);
  endtask

  task automatic test_bpc_sweep();
    int lat, lat2;
    logic [127:0] q, r, x, y;
    for (int g = 0; g < NI; g++) begin
      send(g, 1'b1, PT, lat, q);
      take(g);
      total++; if (q !== CT) $display("FAIL sweep_fwd_bpc%0d: got %h want %h", bpc_of(g), q, CT); else pass_cnt++;
      total++; if (lat != lat_of(g)) $display("FAIL sweep_latency_bpc%0d: got %0d want %0d", bpc_of(g), lat, lat_of(g)); else pass_cnt++;
      r = {$urandom, $urandom, $urandom, $urandom};
      send(g, 1'b1, r, lat, x);
      take(g);
      send(g, 1'b0, x, lat2, y);
      take(g);
      total++; if (y !== r) $display("FAIL sweep_roundtrip_bpc%0d: got %h want %h", bpc_of(g), y, r); else pass_cnt++;
      total++; if (lat2 != lat_of(g)) $display("FAIL sweep_inv_latency_bpc%0d: got %0d want %0d", bpc_of(g), lat2, lat_of(g)); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin [4];
    logic [127:0] vexp [4];
    logic         ven [4];
    logic [127:0] snap;
    int           acc_at [4];
    int           nacc, nout;
    logic         acc, hs;
    vin[0] = PT;        ven[0] = 1'b1; vexp[0] = CT;
    vin[1] = CT;        ven[1] = 1'b0; vexp[1] = PT;
    vin[2] = 128'h0;    ven[2] = 1'b1; vexp[2] = S63;
    vin[3] = S63;       ven[3] = 1'b0; vexp[3] = 128'h0;
    nacc = 0; nout = 0;
    iv[GM] = 1'b1; sin[GM] = vin[0]; en[GM] = ven[0]; ordy[GM] = 1'b1;
    for (int c = 0; c < 200 && nout < 4; c++) begin
      acc  = iv[GM] && ir[GM];
      hs   = ov[GM] && ordy[GM];
      snap = sout[GM];
      @(posedge clk); #1;
      if (acc && nacc < 4) begin
        acc_at[nacc] = c;
        nacc++;
        if (nacc < 4) begin
          sin[GM] = vin[nacc]; en[GM] = ven[nacc];
        end else begin
          iv[GM] = 1'b0;
        end
      end
      if (hs && nout < 4) begin
        total++; if (snap !== vexp[nout]) $display("FAIL b2b_result_%0d: got %h want %h", nout, snap, vexp[nout]); else pass_cnt++;
        nout++;
      end
    end
    iv[GM] = 1'b0; ordy[GM] = 1'b0;
    total++; if (nacc != 4 || nout != 4) $display("FAIL b2b_counts: accepted %0d returned %0d want 4 and 4", nacc, nout); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      if (i < nacc) begin
        total++;
        if (acc_at[i] - acc_at[i-1] != lat_of(GM) + 2)
          $display("FAIL b2b_period_%0d: got %0d want %0d", i, acc_at[i] - acc_at[i-1], lat_of(GM) + 2);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; en[g] = 1'b0; ordy[g] = 1'b0; sin[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_mid_run();
    test_bpc_sweep();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
